nibble_adder_sched: RTL
=======================

# nibble_adder_sched

Round-robin scheduler that shares one 4-bit ripple-carry adder between two requesters. Each request is a multi-nibble add or subtract, executed least-significant nibble first with the carry held in a register between nibbles. The block sits between two client datapaths and a single `adder_4bit` instance. It also owns operand capture, the carry chain across nibbles and result hand-back.

## Interface
Parameters:
- `NIBBLES`, default 4: operand width in nibbles; W = 4*NIBBLES.

Ports:
- `clk`  in  1  single clock; all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req0_valid`  in  1  requester 0 has an operation
- `req0_ready`  out  1  requester 0 operation accepted this cycle
- `req0_in1`, `req0_in2`  in  W  operands (requester 0)
- `req0_sub`  in  1  1 = in1 − in2, 0 = in1 + in2
- `req1_valid`, `req1_ready`, `req1_in1`, `req1_in2`, `req1_sub`: same as above, for requester 1
- `res_valid`  out  1  result available
- `res_ready`  in  1  consumer takes result
- `res_id`  out  1  requester that owns the result
- `res_sum`  out  W  sum/difference
- `res_carry_out`  out  1  final carry (for sub: 1 = no borrow)

Reset is asynchronous, active-low, on `rst_n`; single clock `clk`.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - Arbiter picks a requester among those with valid high.
  - If both are valid, it picks the one not granted last. `last_grant` resets to 1, so requester 0 wins first.
  - `reqN_ready` is combinational and is high only for the granted requester, only in IDLE.
  - On valid&&ready: capture in1, in2 (bitwise inverted if sub), sub and id. Set `carry_reg` = sub, nibble index k = 0, update `last_grant`, go to RUN.
- **RUN**
  - Drive adder with opA[4k+3:4k], opB[4k+3:4k] and `carry_reg`.
  - Write the adder sum into result[4k+3:4k]; `carry_reg` ← adder carry_out; k++.
  - When k = NIBBLES−1 is processed, latch the final carry into `res_carry_out` and go to DONE.
- **DONE**
  - `res_valid` = 1; `res_sum`, `res_id` and `res_carry_out` are stable.
  - On `res_ready` go to IDLE.
  - Both `reqN_ready` are held 0.
- Operands are captured, so requesters may change inputs after their handshake.
- Arithmetic is modulo 2^W; no overflow flag. Sub is in1 + ~in2 + 1.
- k wraps to 0 only via IDLE; it never exceeds NIBBLES−1.

## Timing
- Reset values:
  - state IDLE, `last_grant` = 1, k = 0, `carry_reg` = 0.
  - `res_valid`, `res_id`, `res_sum`, `res_carry_out` all 0.
  - `req0_ready` and `req1_ready` both 0 when neither valid is high.
- Accept at edge T → RUN occupies cycles T..T+NIBBLES−1 → `res_valid` high from edge T+NIBBLES.
- `res_valid` stays high until the cycle with `res_ready` = 1; IDLE follows on the next edge.
- Minimum spacing between accepts: NIBBLES+2 cycles.
- Backpressure: `res_ready` low holds DONE indefinitely with all outputs stable.
- Simultaneous valid from both requesters: exactly one ready is asserted. The loser's valid must stay high; it is granted after the current op completes.
- Reset mid-RUN or mid-DONE: the op is aborted, no `res_valid` pulse, and outputs return to reset values immediately.

## Structure
- Shared package holds:
  - state enum {IDLE, RUN, DONE};
  - requester ID constants REQ0 = 0, REQ1 = 1;
  - nibble width constant 4.
- Sub-modules:
  - one `adder_4bit` instance (existing block, built on `full_adder`);
  - `rr_arb2`, a 2-way round-robin arbiter with a `last_grant` register.
- All sequencing, capture and result registers stay in `nibble_adder_sched`.

## Test plan
All scenarios use NIBBLES = 4.
- Add: req0 0x1234 + 0x0FCD, sub = 0 → `res_sum` 0x2201, carry 0, id 0, `res_valid` 4 cycles after accept.
- Carry chain: req1 0xFFFF + 0x0001 → `res_sum` 0x0000, carry 1, id 1; the carry propagates through all nibbles.
- Subtract:
  - 0x0005 − 0x0007 → 0xFFFE, carry 0 (borrow).
  - 0x0007 − 0x0005 → 0x0002, carry 1.
- Arbitration: after reset, both valid held high with `res_ready` = 1 → grants 0, 1, 0, 1. Never two readies in one cycle.
- Backpressure: `res_ready` low for 10 cycles in DONE → `res_valid`, `res_sum` and `res_id` are stable, both req_ready are 0, and requester 0 may change its inputs without effect.
- Reset mid-op: assert `rst_n` = 0 after 2 RUN cycles → all outputs 0 asynchronously, no result is delivered, and the first grant after release goes to requester 0.

Source files
------------

// File: rtl/nibble_adder_sched_pkg.sv
// Shared types and constants for the nibble-serial add/sub scheduler.
package nibble_adder_sched_pkg;

  localparam int unsigned NIB_W = 4;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/adder_4bit.sv
// Four-bit ripple-carry adder built from full_adder cells.
module adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] c;

  assign c[0] = cin;
  assign cout = c[4];

  for (genvar i = 0; i < 4; i++) begin : g_bit
    full_adder u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (c[i]),
      .s   (sum[i]),
      .cout(c[i+1])
    );
  end

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the requester not granted last wins a tie.
module rr_arb2
  import nibble_adder_sched_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0_c,
  output logic gnt1_c
);

  logic last_grant_q, last_grant_d;

  // A grant is always taken by the requester, so it also updates history.
  always_comb begin
    gnt0_c       = en && req0 && (!req1 || (last_grant_q == REQ1));
    gnt1_c       = en && req1 && (!req0 || (last_grant_q == REQ0));
    last_grant_d = last_grant_q;
    if (gnt0_c)      last_grant_d = REQ0;
    else if (gnt1_c) last_grant_d = REQ1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_grant_q <= REQ1;
    else        last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/nibble_adder_sched.sv
// Shares one 4-bit adder between two requesters, running each multi-nibble
// add/sub LSB nibble first with the carry held between nibbles.
module nibble_adder_sched
  import nibble_adder_sched_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req0_valid,
  output logic                       req0_ready,
  input  logic [NIB_W*NIBBLES-1:0]   req0_in1,
  input  logic [NIB_W*NIBBLES-1:0]   req0_in2,
  input  logic                       req0_sub,
  input  logic                       req1_valid,
  output logic                       req1_ready,
  input  logic [NIB_W*NIBBLES-1:0]   req1_in1,
  input  logic [NIB_W*NIBBLES-1:0]   req1_in2,
  input  logic                       req1_sub,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic                       res_id,
  output logic [NIB_W*NIBBLES-1:0]   res_sum,
  output logic                       res_carry_out
);

  localparam int unsigned W   = NIB_W * NIBBLES;
  localparam int unsigned K_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_e           state_q, state_d;
  logic [K_W-1:0]   k_q, k_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     opa_q, opa_d, opb_q, opb_d;
  logic [W-1:0]     res_sum_q, res_sum_d;
  logic             res_id_q, res_id_d;
  logic             res_carry_q, res_carry_d;
  logic             res_valid_q, res_valid_d;

  logic             gnt0_c, gnt1_c, accept_c, last_nib_c, sel_sub_c;
  logic [NIB_W-1:0] nib_a_c, nib_b_c, nib_s_c;
  logic             nib_co_c;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state_q == IDLE),
    .req0  (req0_valid),
    .req1  (req1_valid),
    .gnt0_c(gnt0_c),
    .gnt1_c(gnt1_c)
  );

  adder_4bit u_add (
    .a   (nib_a_c),
    .b   (nib_b_c),
    .cin (carry_q),
    .sum (nib_s_c),
    .cout(nib_co_c)
  );

  assign accept_c   = gnt0_c | gnt1_c;
  assign sel_sub_c  = gnt1_c ? req1_sub : req0_sub;
  assign last_nib_c = (k_q == K_W'(NIBBLES - 1));

  // Current nibble of each captured operand.
  always_comb begin
    nib_a_c = '0;
    nib_b_c = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (k_q == K_W'(i)) begin
        nib_a_c = opa_q[i*NIB_W +: NIB_W];
        nib_b_c = opb_q[i*NIB_W +: NIB_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_c)   state_d = RUN;
      RUN:     if (last_nib_c) state_d = DONE;
      DONE:    if (res_ready)  state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // Capture, nibble sequencing and result registers.
  always_comb begin
    k_d         = k_q;
    carry_d     = carry_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    res_sum_d   = res_sum_q;
    res_id_d    = res_id_q;
    res_carry_d = res_carry_q;
    res_valid_d = res_valid_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          opa_d    = gnt1_c ? req1_in1 : req0_in1;
          opb_d    = gnt1_c ? req1_in2 : req0_in2;
          if (sel_sub_c) opb_d = ~opb_d;
          carry_d  = sel_sub_c;
          res_id_d = gnt1_c ? REQ1 : REQ0;
          k_d      = '0;
        end
      end
      RUN: begin
        for (int i = 0; i < NIBBLES; i++) begin
          if (k_q == K_W'(i)) res_sum_d[i*NIB_W +: NIB_W] = nib_s_c;
        end
        carry_d = nib_co_c;
        if (last_nib_c) begin
          k_d         = '0;
          res_carry_d = nib_co_c;
          res_valid_d = 1'b1;
        end else begin
          k_d = k_q + K_W'(1);
        end
      end
      DONE: begin
        if (res_ready) res_valid_d = 1'b0;
      end
      default: begin
        res_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q         <= '0;
      carry_q     <= 1'b0;
      opa_q       <= '0;
      opb_q       <= '0;
      res_sum_q   <= '0;
      res_id_q    <= 1'b0;
      res_carry_q <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      k_q         <= k_d;
      carry_q     <= carry_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      res_sum_q   <= res_sum_d;
      res_id_q    <= res_id_d;
      res_carry_q <= res_carry_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign req0_ready    = gnt0_c;
  assign req1_ready    = gnt1_c;
  assign res_valid     = res_valid_q;
  assign res_id        = res_id_q;
  assign res_sum       = res_sum_q;
  assign res_carry_out = res_carry_q;

endmodule
